// File: rtl/oam_dma_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl_pkg
// Description : Shared constants and state type for the sprite (OAM) DMA
//               engine behind the $4014 register.
// Revision    : 1.0 - initial release
// ============================================================================
package oam_dma_ctrl_pkg;

   // CPU address whose write starts a sprite DMA
   localparam logic [15:0] c_dma_reg_addr   = 16'h4014;
   // Sprite RAM size, also the default bytes per transfer
   localparam int          c_oam_size       = 256;
   // Dummy halt cycles that let the CPU reach a read-aligned point
   localparam int          c_align_cycles   = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_READ  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } dma_state_e;

   // True for a CPU write cycle that targets the DMA trigger register
   function automatic logic is_dma_trigger(input logic [15:0] addr,
                                           input logic        we,
                                           input logic [15:0] reg_addr);
      return we && (addr == reg_addr);
   endfunction

endpackage : oam_dma_ctrl_pkg
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl
// Description : Sprite DMA engine. A CPU write to the trigger register halts
//               the CPU and copies XFER_LEN bytes from page {data,8'h00}
//               (read via mem_ctrl) into sprite RAM starting at OAMADDR.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl
   import oam_dma_ctrl_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = c_dma_reg_addr,
   parameter int          XFER_LEN     = c_oam_size,
   parameter int          ALIGN_CYCLES = c_align_cycles
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   input  logic        cpu_write_en,
   input  logic [7:0]  oam_base_addr,
   input  logic        mem_busy,
   input  logic [7:0]  mem_rd_data,
   output logic [15:0] mem_addr,
   output logic        mem_read_en,
   output logic [7:0]  spram_addr,
   output logic [7:0]  spram_wdata,
   output logic        spram_we,
   output logic        cpu_halt_req,
   output logic        dma_busy,
   output logic        dma_done
);

   // Index of the final byte; count is 9 bits so a 256-byte run still ends
   localparam logic [8:0] c_last_idx   = 9'(XFER_LEN - 1);
   // Final alignment cycle; unused when ALIGN_CYCLES is 0 (ALIGN is skipped)
   localparam logic [7:0] c_align_last = 8'(ALIGN_CYCLES - 1);

   dma_state_e  state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  ptr_q, ptr_d;
   logic [8:0]  count_q, count_d;
   logic [7:0]  align_cnt_q, align_cnt_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic        mem_read_en_q, mem_read_en_d;
   logic [7:0]  spram_addr_q, spram_addr_d;
   logic [7:0]  spram_wdata_q, spram_wdata_d;
   logic        spram_we_q, spram_we_d;
   logic        halt_q, halt_d;
   logic        done_q, done_d;

   // Next-state, datapath and registered-output logic; outputs are derived
   // from the next state so they line up with the state they belong to
   always_comb begin
      state_d       = state_q;
      page_d        = page_q;
      ptr_d         = ptr_q;
      count_d       = count_q;
      align_cnt_d   = align_cnt_q;
      mem_addr_d    = mem_addr_q;
      spram_addr_d  = spram_addr_q;
      spram_wdata_d = spram_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (is_dma_trigger(cpu_addr, cpu_write_en, DMA_REG_ADDR)) begin
               page_d      = cpu_data;
               ptr_d       = oam_base_addr;
               count_d     = 9'd0;
               align_cnt_d = 8'd0;
               state_d     = (ALIGN_CYCLES == 0) ? ST_READ : ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            align_cnt_d = align_cnt_q + 8'd1;
            if (align_cnt_q == c_align_last) begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Data is valid on the first non-busy cycle after the request
            if (!mem_busy) begin
               spram_wdata_d = mem_rd_data;
               spram_addr_d  = ptr_q;
               state_d       = ST_WRITE;
            end
         end
         ST_WRITE: begin
            ptr_d   = ptr_q + 8'd1;
            count_d = count_q + 9'd1;
            state_d = (count_q == c_last_idx) ? ST_DONE : ST_READ;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Low address byte is the byte index only; no carry into the page
      if (state_d == ST_READ) begin
         mem_addr_d = {page_d, count_d[7:0]};
      end

      mem_read_en_d = (state_d == ST_READ);
      spram_we_d    = (state_d == ST_WRITE);
      halt_d        = (state_d != ST_IDLE);
      done_d        = (state_d == ST_DONE);
   end

   // State and output registers; reset aborts any transfer in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         page_q        <= 8'd0;
         ptr_q         <= 8'd0;
         count_q       <= 9'd0;
         align_cnt_q   <= 8'd0;
         mem_addr_q    <= 16'd0;
         mem_read_en_q <= 1'b0;
         spram_addr_q  <= 8'd0;
         spram_wdata_q <= 8'd0;
         spram_we_q    <= 1'b0;
         halt_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         page_q        <= page_d;
         ptr_q         <= ptr_d;
         count_q       <= count_d;
         align_cnt_q   <= align_cnt_d;
         mem_addr_q    <= mem_addr_d;
         mem_read_en_q <= mem_read_en_d;
         spram_addr_q  <= spram_addr_d;
         spram_wdata_q <= spram_wdata_d;
         spram_we_q    <= spram_we_d;
         halt_q        <= halt_d;
         done_q        <= done_d;
      end
   end

   assign mem_addr     = mem_addr_q;
   assign mem_read_en  = mem_read_en_q;
   assign spram_addr   = spram_addr_q;
   assign spram_wdata  = spram_wdata_q;
   assign spram_we     = spram_we_q;
   assign cpu_halt_req = halt_q;
   assign dma_busy     = halt_q;
   assign dma_done     = done_q;

endmodule : oam_dma_ctrl
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_ctrl
// Description : Directed self-checking bench for the sprite DMA engine, with
//               a behavioural mem_ctrl model of configurable busy time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_data = 8'h00;
   logic        cpu_write_en = 1'b0;
   logic [7:0]  oam_base_addr = 8'h00;
   logic        mem_busy = 1'b0;
   logic [7:0]  mem_rd_data = 8'h00;
   logic [15:0] mem_addr;
   logic        mem_read_en;
   logic [7:0]  spram_addr;
   logic [7:0]  spram_wdata;
   logic        spram_we;
   logic        cpu_halt_req;
   logic        dma_busy;
   logic        dma_done;

   int total = 0;
   int bad   = 0;

   // Monitor state
   int          busy_cycles = 0;
   int          busy_cnt    = 0;
   int          halt_cnt, done_cnt, rd_cnt, wr_cnt, overlap_cnt;
   logic [15:0] last_rd;
   logic [7:0]  wr_addr [0:511];
   logic [7:0]  wr_data [0:511];

   oam_dma_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_addr      (cpu_addr),
      .cpu_data      (cpu_data),
      .cpu_write_en  (cpu_write_en),
      .oam_base_addr (oam_base_addr),
      .mem_busy      (mem_busy),
      .mem_rd_data   (mem_rd_data),
      .mem_addr      (mem_addr),
      .mem_read_en   (mem_read_en),
      .spram_addr    (spram_addr),
      .spram_wdata   (spram_wdata),
      .spram_we      (spram_we),
      .cpu_halt_req  (cpu_halt_req),
      .dma_busy      (dma_busy),
      .dma_done      (dma_done)
   );

   always #20 clk = ~clk;

   // CPU memory contents: page 2 is addr[7:0]^A5, other pages also mix in the page
   function automatic logic [7:0] mem_at(input logic [15:0] a);
      return a[7:0] ^ 8'hA5 ^ ((a[15:8] == 8'h02) ? 8'h00 : a[15:8]);
   endfunction

   // mem_ctrl model and bus monitor, both on the falling edge
   always @(negedge clk) begin
      if (mem_read_en) begin
         busy_cnt    = busy_cycles;
         mem_rd_data = mem_at(mem_addr);
         mem_busy    = 1'b1;
      end else begin
         mem_busy = (busy_cnt != 0);
         if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
      end
      if (cpu_halt_req) halt_cnt = halt_cnt + 1;
      if (dma_done) done_cnt = done_cnt + 1;
      if (mem_read_en) begin
         rd_cnt  = rd_cnt + 1;
         last_rd = mem_addr;
      end
      if (spram_we) begin
         if (wr_cnt < 512) begin
            wr_addr[wr_cnt] = spram_addr;
            wr_data[wr_cnt] = spram_wdata;
         end
         wr_cnt = wr_cnt + 1;
      end
      if ((mem_read_en && spram_we) || (cpu_halt_req != dma_busy)) overlap_cnt = overlap_cnt + 1;
   end

   task automatic clear_mon();
      halt_cnt = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0; overlap_cnt = 0; last_rd = 16'h0000;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic we);
      @(negedge clk);
      cpu_addr = a; cpu_data = d; cpu_write_en = we;
      @(negedge clk);
      cpu_write_en = 1'b0; cpu_addr = 16'h0000;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done_cnt == 0) begin
         bad++;
         $display("FAIL %s timeout: done_cnt=%0d required>=1 after %0d cycles", name, done_cnt, n);
      end
      repeat (3) @(negedge clk);
   endtask

   // Checks every captured write against memory at {page, idx}, wrapping from base
   task automatic check_writes(input logic [7:0] page, input logic [7:0] base, input string name);
      int errs = 0;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] ea = base + 8'(i);
         logic [7:0] ed = mem_at({page, 8'(i)});
         if (wr_addr[i] !== ea || wr_data[i] !== ed) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL %s data: bad_entries=%0d required=0 (entry0 addr=%h data=%h)", name, errs, wr_addr[0], wr_data[0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({mem_addr, mem_read_en, spram_addr, spram_wdata, spram_we, cpu_halt_req, dma_busy, dma_done} !== 38'd0) begin
         bad++;
         $display("FAIL reset_outputs: got=%h required=0",
                  {mem_addr, mem_read_en, spram_addr, spram_wdata, spram_we, cpu_halt_req, dma_busy, dma_done});
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      busy_cycles = 0; oam_base_addr = 8'h00;
      clear_mon();
      cpu_write(16'h4014, 8'h02, 1'b1);
      wait_done(2000, "basic");
      check_int("basic_writes", wr_cnt, 256);
      check_writes(8'h02, 8'h00, "basic");
      check_int("basic_halt", halt_cnt, 770);
      check_int("basic_done", done_cnt, 1);
      check_int("basic_overlap", overlap_cnt, 0);
   endtask

   task automatic test_wrap();
      busy_cycles = 0; oam_base_addr = 8'hF0;
      clear_mon();
      cpu_write(16'h4014, 8'h03, 1'b1);
      wait_done(2000, "wrap");
      check_int("wrap_first_addr", int'(wr_addr[0]), 'hF0);
      check_int("wrap_first_data", int'(wr_data[0]), int'(mem_at(16'h0300)));
      check_int("wrap_byte16_addr", int'(wr_addr[16]), 'h00);
      check_int("wrap_last_addr", int'(wr_addr[255]), 'hEF);
      check_writes(8'h03, 8'hF0, "wrap");
   endtask

   task automatic test_busy();
      busy_cycles = 5; oam_base_addr = 8'h00;
      clear_mon();
      cpu_write(16'h4014, 8'h02, 1'b1);
      wait_done(5000, "busy");
      check_writes(8'h02, 8'h00, "busy");
      check_int("busy_halt", halt_cnt, 1 + 256 * 8 + 1);
      check_int("busy_reads", rd_cnt, 256);
      check_int("busy_writes", wr_cnt, 256);
      busy_cycles = 0;
   endtask

   task automatic test_back_to_back();
      int n = 0;
      busy_cycles = 0; oam_base_addr = 8'h00;
      clear_mon();
      cpu_write(16'h4014, 8'h02, 1'b1);
      while (wr_cnt < 100 && n < 1000) begin @(negedge clk); n++; end
      cpu_write(16'h4014, 8'h05, 1'b1);
      wait_done(2000, "retrig");
      check_writes(8'h02, 8'h00, "retrig");
      check_int("retrig_done", done_cnt, 1);
      check_int("retrig_reads", rd_cnt, 256);
      repeat (20) @(negedge clk);
      check_int("retrig_no_queue", halt_cnt, 770);
   endtask

   task automatic test_abort();
      int n = 0;
      busy_cycles = 0; oam_base_addr = 8'h00;
      clear_mon();
      cpu_write(16'h4014, 8'h02, 1'b1);
      while (wr_cnt < 50 && n < 1000) begin @(negedge clk); n++; end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({mem_addr, mem_read_en, spram_addr, spram_wdata, spram_we, cpu_halt_req, dma_busy, dma_done} !== 38'd0) begin
         bad++;
         $display("FAIL abort_outputs: got=%h required=0",
                  {mem_addr, mem_read_en, spram_addr, spram_wdata, spram_we, cpu_halt_req, dma_busy, dma_done});
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check_int("abort_writes", wr_cnt, 50);
      check_int("abort_done", done_cnt, 0);
      clear_mon();
      cpu_write(16'h4014, 8'h02, 1'b1);
      wait_done(2000, "restart");
      check_int("restart_writes", wr_cnt, 256);
      check_writes(8'h02, 8'h00, "restart");
   endtask

   task automatic test_no_trigger();
      busy_cycles = 0; oam_base_addr = 8'h00;
      clear_mon();
      cpu_write(16'h4015, 8'h02, 1'b1);
      cpu_write(16'h4014, 8'h02, 1'b0);
      repeat (20) @(negedge clk);
      check_int("notrig_halt", halt_cnt, 0);
      check_int("notrig_reads", rd_cnt, 0);
   endtask

   task automatic test_page_ff();
      busy_cycles = 0; oam_base_addr = 8'h00;
      clear_mon();
      cpu_write(16'h4014, 8'hFF, 1'b1);
      wait_done(2000, "pageff");
      check_int("pageff_last_rd", int'(last_rd), 'hFFFF);
      check_writes(8'hFF, 8'h00, "pageff");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_busy();
      test_back_to_back();
      test_abort();
      test_no_trigger();
      test_page_ff();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_oam_dma_ctrl
`default_nettype wire
